alu_serial_nbit: RTL and testbench
==================================

Name: alu_serial_nbit

Overview:
- Bit-serial N-bit ALU and successor to the 1-bit ALU slice: one full-adder/logic slice is iterated over WIDTH bits, LSB first, one bit per clock.
- Operands and mode are captured on a start handshake. The result, carry and zero flags are held until the next start.
- Used where area matters more than latency, for example datapath helpers beside the register file.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range 2..32.

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request; sampled only when BUSY=0
- MODE  input  3  opcode: 000 ADD, 001 AND, 010 OR, 011 XOR, 100 XNOR
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- C_in  input  1  carry-in; used in ADD only
- BUSY  output  1  high while bits are being processed
- DONE  output  1  one-cycle pulse when the result is valid
- X  output  WIDTH  result, held stable from DONE until the next accepted START
- C_out  output  1  final carry (ADD); 0 for logic modes
- ZERO  output  1  X == 0, valid with X
- MODE_ERR  output  1  set when the last accepted MODE was illegal

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: FSM=IDLE; BUSY=0, DONE=0, X=0, C_out=0, ZERO=1, MODE_ERR=0; internal shift/carry/bit counter cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE/FIN with START=1 at an edge:
  - Capture A, B, MODE and C_in.
  - Load carry = C_in for ADD, 0 otherwise.
  - Clear counter and MODE_ERR; go to RUN.
  - Exception: illegal MODE (101..111) goes directly to FIN with X=0, C_out=0, ZERO=1, MODE_ERR=1.
- RUN, per edge:
  - Compute bit i from A[i], B[i] and the stored carry.
  - ADD: sum = A^B^c, carry = majority(A,B,c). Logic modes: bitwise op, carry held at 0.
  - Shift the result bit into X from the MSB side, so X is LSB-aligned after WIDTH shifts.
  - Increment the counter; after the WIDTH-th bit go to FIN.
- FIN: DONE=1 for exactly that cycle; C_out and ZERO are updated; then IDLE.
  - START in FIN is accepted exactly as in IDLE (back-to-back operation). DONE still pulses for the finishing operation.
- Latency: START accepted at edge k → DONE high during the cycle after edge k+WIDTH. BUSY is high from edge k to edge k+WIDTH.
- START while BUSY=1: ignored, with no side effects. Input changes during RUN are ignored because the operands are captured.
- X during RUN: partially shifted, not valid. Consumers use DONE only. X, C_out, ZERO and MODE_ERR hold after FIN until the next accepted START.
- Carry chain:
  - Carry at WIDTH wraps out to C_out only; the sum is modulo 2^WIDTH.
  - ADD of all-ones + 1 gives X=0, C_out=1, ZERO=1.
- Reset asserted mid-RUN: immediate return to reset values, and no DONE is produced. After deassertion the first edge may accept START.

Optional Feature:
- Macro: ALU_SERIAL_SUB_EN.
- Defined:
  - MODE 101 = SUB, computing A - B as A + ~B + 1. C_in is ignored and the carry is preloaded to 1.
  - C_out=1 means no borrow (A >= B unsigned).
  - An extra output V (1 bit, reset 0) gives signed overflow for ADD and SUB: the carry into the MSB XOR the carry out. V=0 in logic modes.
- Not defined: MODE 101 is illegal (MODE_ERR path) and port V does not exist.

Test Plan:
- WIDTH=8, MODE=ADD, A=0x3C, B=0x55, C_in=1 → after 8 RUN cycles DONE pulse, X=0x92, C_out=0, ZERO=0, BUSY high for exactly 8 cycles.
- MODE=ADD, A=0xFF, B=0x00, C_in=1 → X=0x00, C_out=1, ZERO=1.
- Sweep MODE=AND/OR/XOR/XNOR with A=0xF0, B=0xCC → X=0xC0/0xFC/0x3C/0xC3, C_out=0 in every case.
- START pulsed mid-RUN with different operands → ignored, first result intact. START held during the FIN cycle → new operation begins, DONE pulses once per operation.
- MODE=110 → DONE the cycle after START (no RUN), MODE_ERR=1, X=0. Next legal op clears MODE_ERR.
- RST_N low at RUN bit 4 → outputs at reset values immediately, no DONE. With ALU_SERIAL_SUB_EN, SUB A=0x80, B=0x01 → X=0x7F, C_out=1, V=1.

Source files
------------

// File: rtl/alu_serial_nbit_if.sv
// Bus bundle for the bit-serial ALU. With ALU_SERIAL_SUB_EN defined the
// bundle also carries the signed-overflow flag v.
//
// Handshake: the master raises start with mode/a/b/c_in valid; the ALU takes
// them at the first rising edge where busy=0 (idle or finishing). A start seen
// while busy=1 is dropped. done pulses for one cycle when x/c_out/zero/mode_err
// are valid, and those results hold until the next accepted start.
interface alu_serial_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] x;
    logic             c_out;
    logic             zero;
    logic             mode_err;
`ifdef ALU_SERIAL_SUB_EN
    logic             v;

    modport master (
        output start, mode, a, b, c_in,
        input  busy, done, x, c_out, zero, mode_err, v
    );
    modport slave (
        input  start, mode, a, b, c_in,
        output busy, done, x, c_out, zero, mode_err, v
    );
`else
    modport master (
        output start, mode, a, b, c_in,
        input  busy, done, x, c_out, zero, mode_err
    );
    modport slave (
        input  start, mode, a, b, c_in,
        output busy, done, x, c_out, zero, mode_err
    );
`endif
endinterface

// File: rtl/alu_serial_nbit.sv
// Bit-serial WIDTH-bit ALU: one add/logic slice walks the operands LSB first.
// Optional macro ALU_SERIAL_SUB_EN adds MODE 101 = SUB and the overflow flag v.
module alu_serial_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_serial_nbit_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, x_r;
    logic [2:0]       mode_r;
    logic [CW-1:0]    cnt;
    logic             carry, c_out_r, zero_r, mode_err_r;
    logic             accept, mode_legal, last_bit;
    logic             b_bit, r_bit, carry_nxt, is_arith, is_sub;
    logic [WIDTH-1:0] x_nxt;
`ifdef ALU_SERIAL_SUB_EN
    logic             v_r;
`endif

    always_comb begin
        accept   = bus.start && (state != RUN);
        last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
`ifdef ALU_SERIAL_SUB_EN
        mode_legal = (bus.mode <= OP_SUB);
        is_sub     = (mode_r == OP_SUB);
`else
        mode_legal = (bus.mode <= OP_XNOR);
        is_sub     = 1'b0;
`endif
        is_arith = (mode_r == OP_ADD) || is_sub;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (accept) state_nxt = mode_legal ? RUN : FIN;
            end
            RUN:     if (last_bit) state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // One slice: subtraction feeds the inverted B bit with the carry preloaded to 1.
    always_comb begin
        b_bit     = b_r[0] ^ is_sub;
        r_bit     = 1'b0;
        carry_nxt = 1'b0;
        case (mode_r)
            OP_AND:  r_bit = a_r[0] & b_bit;
            OP_OR:   r_bit = a_r[0] | b_bit;
            OP_XOR:  r_bit = a_r[0] ^ b_bit;
            OP_XNOR: r_bit = ~(a_r[0] ^ b_bit);
            default: begin
                if (is_arith) begin
                    r_bit     = a_r[0] ^ b_bit ^ carry;
                    carry_nxt = (a_r[0] & b_bit) | (a_r[0] & carry) | (b_bit & carry);
                end
            end
        endcase
        x_nxt = {r_bit, x_r[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            x_r        <= '0;
            mode_r     <= OP_ADD;
            cnt        <= '0;
            carry      <= 1'b0;
            c_out_r    <= 1'b0;
            zero_r     <= 1'b1;
            mode_err_r <= 1'b0;
`ifdef ALU_SERIAL_SUB_EN
            v_r        <= 1'b0;
`endif
        end else if (accept) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            mode_r     <= bus.mode;
            cnt        <= '0;
            mode_err_r <= 1'b0;
            carry      <= 1'b0;
            if (bus.mode == OP_ADD) carry <= bus.c_in;
`ifdef ALU_SERIAL_SUB_EN
            if (bus.mode == OP_SUB) carry <= 1'b1;
`endif
            // Illegal opcodes skip RUN and present a clean zero result in FIN.
            if (!mode_legal) begin
                x_r        <= '0;
                c_out_r    <= 1'b0;
                zero_r     <= 1'b1;
                mode_err_r <= 1'b1;
`ifdef ALU_SERIAL_SUB_EN
                v_r        <= 1'b0;
`endif
            end
        end else if (state == RUN) begin
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            x_r   <= x_nxt;
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                c_out_r <= carry_nxt;
                zero_r  <= (x_nxt == '0);
`ifdef ALU_SERIAL_SUB_EN
                v_r     <= is_arith & (carry ^ carry_nxt);
`endif
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == FIN);
    assign bus.x        = x_r;
    assign bus.c_out    = c_out_r;
    assign bus.zero     = zero_r;
    assign bus.mode_err = mode_err_r;
`ifdef ALU_SERIAL_SUB_EN
    assign bus.v        = v_r;
`endif
    assign dbg_state    = state;
endmodule

// File: tb/tb_alu_serial_nbit.sv
// Self-checking bench for alu_serial_nbit: directed cases plus random ops
// scored against an arithmetic reference model.
module tb_alu_serial_nbit;
    localparam int W = 8;
    localparam int RW = W + 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    int         done_cnt;
    logic [RW-1:0] exp_q[$];

    alu_serial_nbit_if #(.WIDTH(W)) bus ();

    alu_serial_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: packed {mode_err, v, zero, c_out, x}
    function automatic logic [RW-1:0] model(input logic [2:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic ci);
        logic [W:0]   s;
        logic [W:0]   ci_w;
        logic [W-1:0] x;
        logic         c, v, err;
        ci_w = '0;
        ci_w[0] = ci;
        s = '0; x = '0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (m)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + ci_w;
                x = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (x[W-1] != a[W-1]);
            end
            3'd1: x = a & b;
            3'd2: x = a | b;
            3'd3: x = a ^ b;
            3'd4: x = ~(a ^ b);
`ifdef ALU_SERIAL_SUB_EN
            3'd5: begin
                s = {1'b0, a} - {1'b0, b};
                x = s[W-1:0];
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (x[W-1] != a[W-1]);
            end
`endif
            default: err = 1'b1;
        endcase
        return {err, v, (x == '0), c, x};
    endfunction

    // scoreboard: every done pulse retires the oldest expected result
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            logic [RW-1:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 64'(bus.done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_val("x", 64'(bus.x), 64'(e[W-1:0]));
                check_val("c_out", 64'(bus.c_out), 64'(e[W]));
                check_val("zero", 64'(bus.zero), 64'(e[W+1]));
                check_val("mode_err", 64'(bus.mode_err), 64'(e[W+3]));
`ifdef ALU_SERIAL_SUB_EN
                check_val("v", 64'(bus.v), 64'(e[W+2]));
`endif
            end
        end
    end

    // driver tasks
    task automatic launch(input logic [2:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = ci;
        exp_q.push_back(model(m, a, b, ci));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) return;
            if (bus.busy) busy_cyc++;
        end
        check_val("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input logic [2:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci);
        int lat, busy_cyc;
        logic illegal;
        logic [RW-1:0] e;
        e = model(m, a, b, ci);
        illegal = e[W+3];
        @(negedge clk);
        launch(m, a, b, ci);
        wait_done(lat, busy_cyc);
        check_val("latency", 64'(lat), illegal ? 64'(1) : 64'(W + 1));
        check_val("busy_cycles", 64'(busy_cyc), illegal ? 64'(0) : 64'(W));
        @(negedge clk);
        check_val("done_one_cycle", 64'(bus.done), 64'(0));
        check_val("x_hold", 64'(bus.x), 64'(e[W-1:0]));
    endtask

    initial begin
        int lat, busy_cyc, d0;
        total = 0; bad = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 3'd0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 64'(bus.busy), 64'(0));
        check_val("rst_done", 64'(bus.done), 64'(0));
        check_val("rst_x", 64'(bus.x), 64'(0));
        check_val("rst_c_out", 64'(bus.c_out), 64'(0));
        check_val("rst_zero", 64'(bus.zero), 64'(1));
        check_val("rst_mode_err", 64'(bus.mode_err), 64'(0));
        rst_n = 1'b1;

        // directed cases
        run_op(3'd0, 8'h3C, 8'h55, 1'b1);
        run_op(3'd0, 8'hFF, 8'h00, 1'b1);
        run_op(3'd0, 8'hFF, 8'h01, 1'b0);
        run_op(3'd1, 8'hF0, 8'hCC, 1'b1);
        run_op(3'd2, 8'hF0, 8'hCC, 1'b1);
        run_op(3'd3, 8'hF0, 8'hCC, 1'b0);
        run_op(3'd4, 8'hF0, 8'hCC, 1'b1);
        run_op(3'd6, 8'h12, 8'h34, 1'b0);
        run_op(3'd0, 8'h01, 8'h02, 1'b0);
        run_op(3'd7, 8'hAA, 8'h55, 1'b1);
        run_op(3'd5, 8'h80, 8'h01, 1'b0);

        // start while busy must be dropped
        d0 = done_cnt;
        @(negedge clk);
        launch(3'd0, 8'h11, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd3; bus.a = 8'hFF; bus.b = 8'h0F; bus.c_in = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (W + 6) @(negedge clk);
        check_val("ignored_start_dones", 64'(done_cnt - d0), 64'(1));

        // back-to-back: new start during the finishing cycle
        d0 = done_cnt;
        @(negedge clk);
        launch(3'd0, 8'h7F, 8'h01, 1'b0);
        wait_done(lat, busy_cyc);
        launch(3'd2, 8'h0F, 8'h30, 1'b0);
        wait_done(lat, busy_cyc);
        check_val("b2b_latency", 64'(lat), 64'(W + 1));
        repeat (3) @(negedge clk);
        check_val("b2b_dones", 64'(done_cnt - d0), 64'(2));

        // reset in the middle of a run: no done, reset values at once
        d0 = done_cnt;
        @(negedge clk);
        launch(3'd0, 8'hF0, 8'h0F, 1'b0);
        void'(exp_q.pop_back());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 64'(bus.busy), 64'(0));
        check_val("mid_rst_done", 64'(bus.done), 64'(0));
        check_val("mid_rst_x", 64'(bus.x), 64'(0));
        check_val("mid_rst_zero", 64'(bus.zero), 64'(1));
        check_val("mid_rst_c_out", 64'(bus.c_out), 64'(0));
        repeat (W + 2) @(negedge clk);
        check_val("mid_rst_no_done", 64'(done_cnt - d0), 64'(0));
        rst_n = 1'b1;
        run_op(3'd0, 8'h3C, 8'h55, 1'b1);

        // random operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check_val("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
